// File: rtl/vga_pixel_gen.sv
// vga_pixel_gen: frame-synchronous 12-bit RGB pattern generator behind the VGA timing controller.
// Define VGA_PIXEL_GEN_BOX_EN to compile in the bouncing-box mode and its position registers.
module vga_pixel_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BOX_SIZE        = 32,
    parameter int HD              = 640,
    parameter int VD              = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic [11:0] sw,
    input  logic        btn_mode,
    output logic [11:0] rgb,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        frame_tick
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        M_SOLID   = 2'd0,
        M_BARS    = 2'd1,
        M_CHECKER = 2'd2,
        M_BOX     = 2'd3
    } mode_e;

    logic [11:0]   sw_s1_q, sw_s2_q, sw_cand_q, sw_db_q, sw_db_d;
    logic [CW-1:0] sw_cnt_q, sw_cnt_d;
    logic          btn_s1_q, btn_s2_q, btn_cand_q, btn_db_q, btn_db_d, btn_prev_q;
    logic [CW-1:0] btn_cnt_q, btn_cnt_d;

    mode_e         pend_mode_q, act_mode_q;
    logic [11:0]   act_colour_q;
    logic          vs_prev_q, frame_tick_q, frame_start;
    logic [11:0]   pix_d, rgb_q;
    logic          hs_q, vs_q;
    logic          unused_pos;

    assign unused_pos = ^{x_pos, y_pos};

    // Stable value is taken on the cycle the saturating count reaches its terminal value.
    always_comb begin
        sw_cnt_d = sw_cnt_q;
        if (sw_s2_q != sw_cand_q)    sw_cnt_d = '0;
        else if (sw_cnt_q != CNT_MAX) sw_cnt_d = sw_cnt_q + CW'(1);
        sw_db_d = ((sw_s2_q == sw_cand_q) && (sw_cnt_d == CNT_MAX)) ? sw_cand_q : sw_db_q;

        btn_cnt_d = btn_cnt_q;
        if (btn_s2_q != btn_cand_q)    btn_cnt_d = '0;
        else if (btn_cnt_q != CNT_MAX) btn_cnt_d = btn_cnt_q + CW'(1);
        btn_db_d = ((btn_s2_q == btn_cand_q) && (btn_cnt_d == CNT_MAX)) ? btn_cand_q : btn_db_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            sw_cand_q  <= '0;
            sw_cnt_q   <= '0;
            sw_db_q    <= '0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_cand_q <= 1'b0;
            btn_cnt_q  <= '0;
            btn_db_q   <= 1'b0;
        end else begin
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
            sw_cand_q  <= sw_s2_q;
            sw_cnt_q   <= sw_cnt_d;
            sw_db_q    <= sw_db_d;
            btn_s1_q   <= btn_mode;
            btn_s2_q   <= btn_s1_q;
            btn_cand_q <= btn_s2_q;
            btn_cnt_q  <= btn_cnt_d;
            btn_db_q   <= btn_db_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_prev_q  <= 1'b0;
            pend_mode_q <= M_SOLID;
        end else begin
            btn_prev_q <= btn_db_q;
            if (btn_db_q && !btn_prev_q) begin
                case (pend_mode_q)
                    M_SOLID:   pend_mode_q <= M_BARS;
                    M_BARS:    pend_mode_q <= M_CHECKER;
`ifdef VGA_PIXEL_GEN_BOX_EN
                    M_CHECKER: pend_mode_q <= M_BOX;
`else
                    M_CHECKER: pend_mode_q <= M_SOLID;
`endif
                    default:   pend_mode_q <= M_SOLID;
                endcase
            end
        end
    end

    assign frame_start = v_sync_in & ~vs_prev_q;

    // Active settings only change at frame start so a frame never tears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            act_mode_q   <= M_SOLID;
            act_colour_q <= '0;
        end else begin
            vs_prev_q    <= v_sync_in;
            frame_tick_q <= frame_start;
            if (frame_start) begin
                act_mode_q   <= pend_mode_q;
                act_colour_q <= sw_db_q;
            end
        end
    end

`ifdef VGA_PIXEL_GEN_BOX_EN
    logic [9:0]  box_x_q, box_y_q;
    logic        dx_q, dy_q;
    logic [10:0] bx_lo, bx_hi, by_lo, by_hi, px, py;
    logic        in_box;

    assign bx_lo  = {1'b0, box_x_q};
    assign by_lo  = {1'b0, box_y_q};
    assign bx_hi  = bx_lo + 11'(BOX_SIZE);
    assign by_hi  = by_lo + 11'(BOX_SIZE);
    assign px     = {1'b0, x_pos};
    assign py     = {1'b0, y_pos};
    assign in_box = (px >= bx_lo) && (px < bx_hi) && (py >= by_lo) && (py < by_hi);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            box_x_q <= '0;
            box_y_q <= '0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
        end else if (frame_start) begin
            if (dx_q) begin
                if (bx_hi >= 11'(HD - 1)) begin
                    dx_q    <= 1'b0;
                    box_x_q <= box_x_q - 10'd1;
                end else begin
                    box_x_q <= box_x_q + 10'd1;
                end
            end else if (box_x_q == 10'd0) begin
                dx_q    <= 1'b1;
                box_x_q <= box_x_q + 10'd1;
            end else begin
                box_x_q <= box_x_q - 10'd1;
            end
            if (dy_q) begin
                if (by_hi >= 11'(VD - 1)) begin
                    dy_q    <= 1'b0;
                    box_y_q <= box_y_q - 10'd1;
                end else begin
                    box_y_q <= box_y_q + 10'd1;
                end
            end else if (box_y_q == 10'd0) begin
                dy_q    <= 1'b1;
                box_y_q <= box_y_q + 10'd1;
            end else begin
                box_y_q <= box_y_q - 10'd1;
            end
        end
    end
`else
    logic [31:0] unused_box_cfg;
    assign unused_box_cfg = 32'(BOX_SIZE ^ HD ^ VD);
`endif

    always_comb begin
        pix_d = act_colour_q;
        case (act_mode_q)
            M_BARS: pix_d = {x_pos[8] ? act_colour_q[11:8] : 4'h0,
                             x_pos[7] ? act_colour_q[7:4]  : 4'h0,
                             x_pos[6] ? act_colour_q[3:0]  : 4'h0};
            M_CHECKER: pix_d = (x_pos[5] ^ y_pos[5]) ? act_colour_q : ~act_colour_q;
`ifdef VGA_PIXEL_GEN_BOX_EN
            M_BOX: pix_d = in_box ? act_colour_q : 12'h000;
`endif
            default: pix_d = act_colour_q;
        endcase
        if (!video_on) pix_d = 12'h000;
    end

    // Colour and syncs share one p_tick-enabled stage to keep them aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else if (p_tick) begin
            rgb_q <= pix_d;
            hs_q  <= h_sync_in;
            vs_q  <= v_sync_in;
        end
    end

    assign rgb        = rgb_q;
    assign h_sync_out = hs_q;
    assign v_sync_out = vs_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_pixel_gen.sv
// Self-checking bench for vga_pixel_gen: vector table, hand sequences and a randomized
// pixel loop against a frame-level reference model.
module tb_vga_pixel_gen;
    localparam int DB   = 4;
    localparam int BOXS = 32;
    localparam int HDV  = 640;
    localparam int VDV  = 480;
`ifdef VGA_PIXEL_GEN_BOX_EN
    localparam int NMODES = 4;
`else
    localparam int NMODES = 3;
`endif

    logic        clk = 1'b0;
    logic        reset, p_tick, video_on, h_sync_in, v_sync_in, btn_mode;
    logic [9:0]  x_pos, y_pos;
    logic [11:0] sw, rgb;
    logic        h_sync_out, v_sync_out, frame_tick;

    int          checks = 0;
    int          failures = 0;
    int          m_pend, m_act, frames;
    logic [11:0] m_col, m_sw;

    typedef struct {
        int          x;
        int          y;
        bit          von;
        bit          hs;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[10];

    vga_pixel_gen #(.DEBOUNCE_CYCLES(DB), .BOX_SIZE(BOXS), .HD(HDV), .VD(VDV)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .x_pos(x_pos), .y_pos(y_pos),
        .sw(sw), .btn_mode(btn_mode), .rgb(rgb), .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {11'b0, act}, {11'b0, exp});
    endtask

    // Box travels as a triangle wave between 0 and the turn-around position.
    function automatic int tri_pos(input int n, input int peak);
        int p;
        p = n % (2 * peak);
        return (p <= peak) ? p : 2 * peak - p;
    endfunction

    function automatic logic [11:0] model_px(input int mode, input logic [11:0] c,
                                             input int x, input int y, input bit von, input int nfr);
        int idx, bx, by;
        if (!von) return 12'h000;
        case (mode)
            1: begin
                idx = (x / 64) % 8;
                return {(idx >= 4) ? c[11:8] : 4'h0,
                        ((idx / 2) % 2 == 1) ? c[7:4] : 4'h0,
                        (idx % 2 == 1) ? c[3:0] : 4'h0};
            end
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? c : ~c;
            3: begin
                bx = tri_pos(nfr, HDV - 1 - BOXS);
                by = tri_pos(nfr, VDV - 1 - BOXS);
                return (x >= bx && x < bx + BOXS && y >= by && y < by + BOXS) ? c : 12'h000;
            end
            default: return c;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pixel_exp(input int x, input int y, input bit von, input bit hs,
                             input logic [11:0] exp, input string nm);
        x_pos = 10'(x); y_pos = 10'(y); video_on = von; h_sync_in = hs; p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
        chk(nm, rgb, exp);
        chk1({nm, "_hs"}, h_sync_out, hs);
        h_sync_in = ~hs;
        idle(3);
        chk({nm, "_hold"}, rgb, exp);
        chk1({nm, "_hs_hold"}, h_sync_out, hs);
    endtask

    task automatic pixel(input int x, input int y, input bit von, input bit hs, input string nm);
        pixel_exp(x, y, von, hs, model_px(m_act, m_col, x, y, von, frames), nm);
    endtask

    task automatic frame();
        v_sync_in = 1'b1; video_on = 1'b0; p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
        chk1("frame_tick_pulse", frame_tick, 1'b1);
        chk1("vsync_out_high", v_sync_out, 1'b1);
        chk("vblank_rgb", rgb, 12'h000);
        m_act = m_pend; m_col = m_sw; frames++;
        @(negedge clk);
        chk1("frame_tick_single", frame_tick, 1'b0);
        v_sync_in = 1'b0; p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
        chk1("vsync_out_low", v_sync_out, 1'b0);
        @(negedge clk);
    endtask

    task automatic frame_fast();
        v_sync_in = 1'b1;
        @(negedge clk);
        v_sync_in = 1'b0;
        m_act = m_pend; m_col = m_sw; frames++;
        @(negedge clk);
    endtask

    task automatic set_sw(input logic [11:0] v);
        sw = v;
        idle(8);
        m_sw = v;
    endtask

    task automatic press();
        btn_mode = 1'b1;
        idle(10);
        btn_mode = 1'b0;
        idle(10);
        m_pend = (m_pend + 1) % NMODES;
    endtask

    initial begin
        vecs[0] = '{64,  10, 1'b1, 1'b0, 12'h00F};
        vecs[1] = '{127, 10, 1'b1, 1'b1, 12'h00F};
        vecs[2] = '{448, 10, 1'b1, 1'b0, 12'hFFF};
        vecs[3] = '{511, 20, 1'b1, 1'b1, 12'hFFF};
        vecs[4] = '{0,   0,  1'b1, 1'b0, 12'h000};
        vecs[5] = '{128, 0,  1'b1, 1'b1, 12'h0F0};
        vecs[6] = '{192, 5,  1'b1, 1'b0, 12'h0FF};
        vecs[7] = '{256, 0,  1'b1, 1'b1, 12'hF00};
        vecs[8] = '{320, 0,  1'b1, 1'b0, 12'hF0F};
        vecs[9] = '{200, 0,  1'b0, 1'b1, 12'h000};

        reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
        x_pos = '0; y_pos = '0; sw = 12'hFFF; btn_mode = 1'b0;
        m_pend = 0; m_act = 0; m_col = '0; m_sw = '0; frames = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            h_sync_in = i[0]; v_sync_in = i[1]; p_tick = 1'b1; video_on = 1'b1;
            @(negedge clk);
            chk("rst_rgb", rgb, 12'h000);
            chk1("rst_hs", h_sync_out, 1'b0);
            chk1("rst_vs", v_sync_out, 1'b0);
            chk1("rst_ftick", frame_tick, 1'b0);
        end
        p_tick = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; video_on = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk1("no_tick_before_vsync", frame_tick, 1'b0);
        end
        m_sw = 12'hFFF;
        pixel(100, 100, 1'b1, 1'b1, "pre_first_frame");
        frame();
        pixel_exp(5, 5, 1'b1, 1'b0, 12'hFFF, "first_frame_colour");

        sw = 12'hF00;
        idle(10);
        m_sw = 12'hF00;
        pixel_exp(30, 40, 1'b1, 1'b1, 12'hFFF, "gated_midframe");
        frame();
        pixel_exp(30, 40, 1'b1, 1'b0, 12'hF00, "gated_applied");
        pixel(600, 470, 1'b1, 1'b1, "gated_applied2");

        set_sw(12'h000);
        frame();
        for (int i = 0; i < 20; i++) begin
            sw = (i % 2 == 0) ? 12'h0F0 : 12'h000;
            idle(2);
        end
        sw = 12'h0F0;
        idle(5);
        frame();
        pixel_exp(10, 10, 1'b1, 1'b0, 12'h000, "debounce_5clk_rejected");
        m_sw = 12'h0F0;
        frame();
        pixel_exp(10, 10, 1'b1, 1'b1, 12'h0F0, "debounce_settled");
        sw = 12'h00F;
        idle(6);
        m_sw = 12'h00F;
        frame();
        pixel_exp(10, 10, 1'b1, 1'b0, 12'h00F, "debounce_6clk_accepted");

        set_sw(12'hFFF);
        press();
        frame();
        for (int i = 0; i < 10; i++)
            pixel_exp(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].hs, vecs[i].exp, $sformatf("bars_vec%0d", i));

        for (int r = 0; r < 2 * NMODES; r++) begin
            press();
            set_sw(12'($urandom));
            frame();
            for (int k = 0; k < 10; k++) begin
                int rx, ry;
                rx = $urandom_range(0, 1023);
                ry = $urandom_range(0, 1023);
                if (m_act == 3 && k < 6) begin
                    rx = tri_pos(frames, HDV - 1 - BOXS) + $urandom_range(0, 40) - 4;
                    ry = tri_pos(frames, VDV - 1 - BOXS) + $urandom_range(0, 40) - 4;
                    if (rx < 0) rx = 0;
                    if (ry < 0) ry = 0;
                end
                pixel(rx, ry, 1'($urandom_range(0, 3) != 0), 1'($urandom), $sformatf("rand_m%0d", m_act));
            end
        end

        while (m_pend != 0) press();
        set_sw(12'hFFF);
        frame();
        pixel_exp(64, 0, 1'b1, 1'b0, 12'hFFF, "solid_before_press");
        btn_mode = 1'b1;
        idle(6);
        frame();
        m_pend = 1;
        pixel_exp(64, 0, 1'b1, 1'b0, 12'hFFF, "press_at_tick_deferred");
        btn_mode = 1'b0;
        idle(10);
        frame();
        pixel_exp(64, 0, 1'b1, 1'b0, 12'h00F, "press_applied_next_frame");

`ifdef VGA_PIXEL_GEN_BOX_EN
        while (m_pend != 3) press();
        frame();
        while (frames < 447) frame_fast();
        pixel_exp(447, 446, 1'b1, 1'b0, 12'h000, "box_y_peak_above");
        pixel_exp(447, 447, 1'b1, 1'b0, 12'hFFF, "box_y_peak_top");
        pixel_exp(447, 478, 1'b1, 1'b0, 12'hFFF, "box_y_peak_bottom");
        pixel_exp(447, 479, 1'b1, 1'b0, 12'h000, "box_y_peak_below");
        frame_fast();
        pixel_exp(448, 446, 1'b1, 1'b0, 12'hFFF, "box_y_reversed");
        while (frames < 607) frame_fast();
        pixel_exp(607, 287, 1'b1, 1'b0, 12'hFFF, "box_x_peak_in");
        pixel_exp(606, 287, 1'b1, 1'b0, 12'h000, "box_x_peak_left");
        frame_fast();
        pixel_exp(606, 286, 1'b1, 1'b0, 12'hFFF, "box_x_reversed");
        pixel_exp(637, 286, 1'b1, 1'b0, 12'hFFF, "box_x_last_col");
        pixel_exp(638, 286, 1'b1, 1'b0, 12'h000, "box_x_past_edge");
`else
        while (m_pend != 2) press();
        set_sw(12'hF0F);
        frame();
        pixel_exp(0, 0, 1'b1, 1'b0, 12'h0F0, "checker_inverse");
        press();
        frame();
        pixel_exp(0, 0, 1'b1, 1'b0, 12'hF0F, "checker_wraps_to_solid");
`endif

        while (m_pend != 0) press();
        set_sw(12'hABC);
        frame();
        pixel_exp(10, 10, 1'b0, 1'b1, 12'h000, "blank_abc");
        pixel_exp(10, 10, 1'b1, 1'b0, 12'hABC, "unblank_abc");

        video_on = 1'b1; p_tick = 1'b1; x_pos = 10'd10; y_pos = 10'd10;
        #2 reset = 1'b0;
        #1;
        chk("midframe_rst_rgb", rgb, 12'h000);
        chk1("midframe_rst_hs", h_sync_out, 1'b0);
        chk1("midframe_rst_vs", v_sync_out, 1'b0);
        @(negedge clk);
        p_tick = 1'b0;
        reset = 1'b1;
        m_pend = 0; m_act = 0; m_col = '0; frames = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk1("post_rst_no_tick", frame_tick, 1'b0);
        end
        m_sw = 12'hABC;
        pixel(10, 10, 1'b1, 1'b1, "post_rst_colour_cleared");
        frame();
        pixel(10, 10, 1'b1, 1'b0, "post_rst_first_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
